// File: rtl/shifter_pipe_pkg.sv
// Shared shift/rotate operation encodings; the ALU decode imports the same
// package so both sides agree on the op field.
package shifter_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

  localparam int OP_W = 2;

endpackage

// File: rtl/shifter_stage.sv
// One level of the log-shifter: fixed shift distance 2^LEVEL, selected by
// shamt bit LEVEL, followed by a valid/ready pipeline register.
module shifter_stage
  import shifter_pipe_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SHW      = 4,
  parameter int LEVEL    = 0,
  parameter bit RST_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic [OP_W-1:0]  up_op,
  input  logic [SHW-1:0]   up_shamt,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [OP_W-1:0]  dn_op,
  output logic [SHW-1:0]   dn_shamt
);

  localparam int DIST = 1 << LEVEL;

  // SRA fill comes from the current MSB; every earlier level preserved the
  // original sign bit there, so it always equals the operand's MSB.
  function automatic logic [WIDTH-1:0] shift_fixed(input logic [WIDTH-1:0] d,
                                                   input logic [OP_W-1:0]  op);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    case (shift_op_e'(op))
      OP_ROL:  return (d << DIST) | (d >> (WIDTH - DIST));
      OP_SLL:  return d << DIST;
      OP_ROR:  return (d >> DIST) | (d << (WIDTH - DIST));
      OP_SRA:  return sd >>> DIST;
      default: return d;
    endcase
  endfunction

  logic             r_vld;
  logic [WIDTH-1:0] r_data;
  logic [OP_W-1:0]  r_op;
  logic [SHW-1:0]   r_shamt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_load;

  assign w_shifted = up_shamt[LEVEL] ? shift_fixed(up_data, up_op) : up_data;
  assign up_ready  = ~r_vld | dn_ready;
  assign w_load    = up_ready & up_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (up_ready) begin
      r_vld <= up_valid;
    end
  end

  // Data only moves with a valid operation so a stalled result stays put.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_data  <= w_shifted;
      r_op    <= up_op;
      r_shamt <= up_shamt;
    end
    if (RST_DATA && rst) begin
      r_data <= '0;
    end
  end

  assign dn_valid = r_vld;
  assign dn_data  = r_data;
  assign dn_op    = r_op;
  assign dn_shamt = r_shamt;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: SHW registered log-shift levels with elastic
// valid/ready flow control; results leave in acceptance order.
module shifter_pipe
  import shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Index k is the input of level k; index SHW is the output of the last level.
  logic             w_vld_p   [SHW+1];
  logic             w_rdy_p   [SHW+1];
  logic [WIDTH-1:0] w_data_p  [SHW+1];
  logic [OP_W-1:0]  w_op_p    [SHW+1];
  logic [SHW-1:0]   w_shamt_p [SHW+1];
  logic             w_unused_tail;

  assign w_vld_p[0]      = in_valid;
  assign w_data_p[0]     = in_data;
  assign w_op_p[0]       = in_op;
  assign w_shamt_p[0]    = in_shamt;
  assign w_rdy_p[SHW]    = out_ready;

  genvar k;
  generate
    for (k = 0; k < SHW; k++) begin : g_level
      shifter_stage #(
        .WIDTH    (WIDTH),
        .SHW      (SHW),
        .LEVEL    (k),
        .RST_DATA (k == SHW - 1)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .up_valid (w_vld_p[k]),
        .up_ready (w_rdy_p[k]),
        .up_data  (w_data_p[k]),
        .up_op    (w_op_p[k]),
        .up_shamt (w_shamt_p[k]),
        .dn_valid (w_vld_p[k+1]),
        .dn_ready (w_rdy_p[k+1]),
        .dn_data  (w_data_p[k+1]),
        .dn_op    (w_op_p[k+1]),
        .dn_shamt (w_shamt_p[k+1])
      );
    end
  endgenerate

  // Op and shamt are spent once the last level has used them.
  assign w_unused_tail = ^{w_op_p[SHW], w_shamt_p[SHW]};

  assign in_ready  = w_rdy_p[0] & ~rst;
  assign out_valid = w_vld_p[SHW] & ~rst;
  assign out_data  = w_data_p[SHW];
  assign out_zero  = (w_data_p[SHW] == '0);

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe (WIDTH=16): directed vectors, backpressure,
// randomized traffic against an arithmetic reference model, and mid-flight reset.
module tb_shifter_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;

  int checks = 0;
  int errors = 0;
  int out_xfers = 0;
  logic [15:0] exp_q[$];

  shifter_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d,
                                            input int s);
    logic [31:0]        dd;
    logic signed [31:0] sx;
    logic [31:0]        r;
    dd = {16'h0000, d};
    sx = {{16{d[15]}}, d};
    case (op)
      2'b00:   r = (dd << s) | (dd >> (16 - s));
      2'b01:   r = dd << s;
      2'b10:   r = (dd >> s) | (dd << (16 - s));
      default: r = sx >>> s;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: records accepted operations, checks every delivered result and
  // output stability while stalled.
  initial begin
    logic        stall_pend;
    logic [15:0] stall_data;
    logic [15:0] e;
    stall_pend = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_data", {16'd0, out_data}, {16'd0, stall_data});
        end
        stall_pend = out_valid && !out_ready;
        stall_data = out_data;
        if (in_valid && in_ready)
          exp_q.push_back(ref_shift(in_op, in_data, int'(in_shamt)));
        if (out_valid && out_ready) begin
          out_xfers++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got 0x%0h expected no result", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("sb_data", {16'd0, out_data}, {16'd0, e});
            chk("sb_zero", {31'd0, out_zero}, {31'd0, (e == 16'h0000)});
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] s);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_accept", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] s, input logic [15:0] exp);
    int n;
    send(op, d, s);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({name, "_latency"}, n, 4);
    chk({name, "_data"}, {16'd0, out_data}, {16'd0, exp});
    chk({name, "_zero"}, {31'd0, out_zero}, {31'd0, (exp == 16'h0000)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  bp_op   [6];
    logic [15:0] bp_data [6];
    logic [3:0]  bp_sh   [6];
    int idx;
    int xb;
    int sent;
    int cyc;
    int vcount;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_out_data", {16'd0, out_data}, 32'd0);
    chk("post_rst_out_zero", {31'd0, out_zero}, 32'd1);
    @(posedge clk);
    #1;

    run_vec("rol_8001_1", 2'b00, 16'h8001, 4'd1, 16'h0003);
    run_vec("ror_1234_4", 2'b10, 16'h1234, 4'd4, 16'h4123);
    run_vec("sll_00ff_8", 2'b01, 16'h00FF, 4'd8, 16'hFF00);
    run_vec("sll_0001_15", 2'b01, 16'h0001, 4'd15, 16'h8000);
    run_vec("sll_8000_1", 2'b01, 16'h8000, 4'd1, 16'h0000);
    run_vec("sra_8000_15", 2'b11, 16'h8000, 4'd15, 16'hFFFF);
    run_vec("sra_7ff0_4", 2'b11, 16'h7FF0, 4'd4, 16'h07FF);
    run_vec("rol_by0", 2'b00, 16'hA5C3, 4'd0, 16'hA5C3);
    run_vec("sll_by0", 2'b01, 16'hA5C3, 4'd0, 16'hA5C3);
    run_vec("ror_by0", 2'b10, 16'hA5C3, 4'd0, 16'hA5C3);
    run_vec("sra_by0", 2'b11, 16'hA5C3, 4'd0, 16'hA5C3);

    // Backpressure: six offered, four fit, then drain one per cycle.
    for (int i = 0; i < 6; i++) begin
      bp_op[i]   = 2'($urandom_range(0, 3));
      bp_data[i] = 16'($urandom);
      bp_sh[i]   = 4'($urandom_range(1, 15));
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        in_op = bp_op[idx]; in_data = bp_data[idx]; in_shamt = bp_sh[idx];
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bp_accepted", idx, 4);
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    xb = out_xfers;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        in_op = bp_op[idx]; in_data = bp_data[idx]; in_shamt = bp_sh[idx];
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_drain_per_cycle", out_xfers - xb, 6);
    chk("bp_all_accepted", idx, 6);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Randomized traffic against the reference model.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 2'($urandom_range(0, 3));
      in_data   = 16'($urandom);
      in_shamt  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_sent", sent, 10000);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
    end
    chk("rand_queue_empty", exp_q.size(), 0);

    // Reset with three operations in flight.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      in_valid = 1'b1;
      in_op = 2'b01; in_data = 16'h1111 + 16'(idx); in_shamt = 4'd3;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("rr_inflight", idx, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rr_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rr_out_data", {16'd0, out_data}, 32'd0);
    chk("rr_out_zero", {31'd0, out_zero}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("rr_no_stale", vcount, 0);
    @(posedge clk);
    #1;
    run_vec("rr_next_op", 2'b01, 16'h0003, 4'd2, 16'h000C);
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("rr_result_alone", vcount, 0);
    chk("rr_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
